// File: rtl/link_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_pattern_pkg
// Description : Pattern modes, PRBS taps, seeds and successor function shared
//               by the link pattern generator and checker.
// Revision    : 1.0 - initial release
// ============================================================================
package link_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_COUNTER = 2'd0,
      MODE_PRBS    = 2'd1,
      MODE_FIXED   = 2'd2,
      MODE_WALK1   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_SEEK   = 2'd0,
      ST_ACQ    = 2'd1,
      ST_LOCKED = 2'd2
   } lane_state_e;

   // Tap masks: bit (t-1) set for each polynomial tap t
   localparam logic [31:0] c_prbs_taps_8  = 32'h0000_00B8;
   localparam logic [31:0] c_prbs_taps_16 = 32'h0000_D008;
   localparam logic [31:0] c_prbs_taps_32 = 32'h8020_0003;

   localparam logic [31:0] c_seed_counter = 32'h0000_0000;
   localparam logic [31:0] c_seed_prbs    = 32'h0000_0001;
   localparam logic [31:0] c_seed_walk1   = 32'h0000_0001;

   function automatic logic [31:0] width_mask(input int unsigned dw);
      logic [31:0] m;
      if (dw >= 32) m = 32'hFFFF_FFFF;
      else          m = (32'd1 << dw) - 32'd1;
      return m;
   endfunction

   function automatic logic [31:0] prbs_taps(input int unsigned dw);
      logic [31:0] t;
      case (dw)
         8:       t = c_prbs_taps_8;
         32:      t = c_prbs_taps_32;
         default: t = c_prbs_taps_16;
      endcase
      return t;
   endfunction

   function automatic logic [31:0] pattern_seed(input mode_e mode, input int unsigned dw,
                                                input logic [31:0] fixed_word);
      logic [31:0] s;
      case (mode)
         MODE_COUNTER: s = c_seed_counter;
         MODE_PRBS:    s = c_seed_prbs;
         MODE_FIXED:   s = fixed_word;
         default:      s = c_seed_walk1;
      endcase
      return s & width_mask(dw);
   endfunction

   function automatic logic [31:0] pattern_next(input mode_e mode, input logic [31:0] w,
                                                input int unsigned dw,
                                                input logic [31:0] fixed_word);
      logic [31:0] m;
      logic [31:0] v;
      logic [31:0] r;
      m = width_mask(dw);
      v = w & m;
      case (mode)
         MODE_COUNTER: r = v + 32'd1;
         MODE_PRBS:    r = (v == 32'd0) ? 32'd1 : ((v << 1) | {31'd0, ^(v & prbs_taps(dw))});
         MODE_FIXED:   r = fixed_word;
         default:      r = (v == 32'd0) ? 32'd1 : ((v << 1) | (v >> (dw - 1)));
      endcase
      return r & m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/link_pattern_lane.sv
`default_nettype none
// ============================================================================
// Module      : link_pattern_lane
// Description : One lane: pattern generator plus self-aligning checker with
//               lock tracking and a saturating error counter.
//               Optional: LINK_PATTERN_ERR_INJECT_EN adds one-shot bit-0 error
//               injection on the transmit word.
// Revision    : 1.0 - initial release
// ============================================================================
module link_pattern_lane
   import link_pattern_pkg::*;
#(
   parameter int          DATA_W     = 16,
   parameter int          CNT_W      = 16,
   parameter int          LOCK_N     = 8,
   parameter int          LOSS_N     = 4,
   parameter logic [31:0] FIXED_WORD = 32'h0000_BC50
) (
   input  logic              clk,
   input  logic              rst,
   input  mode_e             cur_mode,
   input  mode_e             new_mode,
   input  logic              reseed,
   input  logic              enable,
   input  logic              clr_cnt,
   input  logic              tx_ready,
`ifdef LINK_PATTERN_ERR_INJECT_EN
   input  logic              inject,
`endif
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              lane_locked,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_pulse
);

   localparam int c_good_w = $clog2(LOCK_N + 1);
   localparam int c_bad_w  = $clog2(LOSS_N + 1);

   logic [DATA_W-1:0]   r_word;
   logic                r_tx_valid;
   logic [DATA_W-1:0]   r_prev;
   lane_state_e         r_state;
   logic [c_good_w-1:0] r_good;
   logic [c_bad_w-1:0]  r_bad;
   logic                r_locked;
   logic [CNT_W-1:0]    r_err_cnt;
   logic                r_err_pulse;

   logic [DATA_W-1:0]   w_expected;
   logic                w_act;
   logic                w_match;
   logic                w_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word     <= DATA_W'(pattern_seed(MODE_COUNTER, DATA_W, FIXED_WORD));
         r_tx_valid <= 1'b0;
      end else begin
         r_tx_valid <= enable;
         if (reseed)
            r_word <= DATA_W'(pattern_seed(new_mode, DATA_W, FIXED_WORD));
         else if (r_tx_valid && tx_ready)
            r_word <= DATA_W'(pattern_next(cur_mode, 32'(r_word), DATA_W, FIXED_WORD));
      end
   end

`ifdef LINK_PATTERN_ERR_INJECT_EN
   logic r_inj_d;
   logic r_inj_pend;

   // A rising edge arms a flip of bit 0 on the next word that is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inj_d    <= 1'b0;
         r_inj_pend <= 1'b0;
      end else begin
         r_inj_d <= inject;
         if (inject && !r_inj_d)
            r_inj_pend <= 1'b1;
         else if (r_tx_valid && tx_ready)
            r_inj_pend <= 1'b0;
      end
   end

   assign tx_data = r_word ^ {{(DATA_W-1){1'b0}}, r_inj_pend};
`else
   assign tx_data = r_word;
`endif
   assign tx_valid = r_tx_valid;

   assign w_expected = DATA_W'(pattern_next(cur_mode, 32'(r_prev), DATA_W, FIXED_WORD));
   assign w_act      = enable && rx_valid;
   assign w_match    = (rx_data == w_expected);
   assign w_err      = w_act && !reseed && (r_state == ST_LOCKED) && !w_match;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev      <= '0;
         r_state     <= ST_SEEK;
         r_good      <= '0;
         r_bad       <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= w_err;
         if (reseed) begin
            r_state  <= ST_SEEK;
            r_good   <= '0;
            r_bad    <= '0;
            r_locked <= 1'b0;
         end else if (w_act) begin
            // prev follows every word so one bad word costs at most two errors
            r_prev <= rx_data;
            case (r_state)
               ST_SEEK: begin
                  r_good  <= '0;
                  r_state <= ST_ACQ;
               end
               ST_ACQ: begin
                  if (!w_match) begin
                     r_good <= '0;
                  end else if (r_good == c_good_w'(LOCK_N - 1)) begin
                     r_state  <= ST_LOCKED;
                     r_locked <= 1'b1;
                     r_bad    <= '0;
                  end else begin
                     r_good <= r_good + 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (w_match) begin
                     r_bad <= '0;
                  end else if (r_bad == c_bad_w'(LOSS_N - 1)) begin
                     r_state  <= ST_ACQ;
                     r_locked <= 1'b0;
                     r_good   <= '0;
                     r_bad    <= '0;
                  end else begin
                     r_bad <= r_bad + 1'b1;
                  end
               end
               default: r_state <= ST_SEEK;
            endcase
         end
      end
   end

   // Clear wins, but an error in the same cycle still counts once
   always_ff @(posedge clk) begin
      if (rst)
         r_err_cnt <= '0;
      else if (clr_cnt)
         r_err_cnt <= w_err ? CNT_W'(1) : '0;
      else if (w_err && (r_err_cnt != {CNT_W{1'b1}}))
         r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign lane_locked = r_locked;
   assign err_cnt     = r_err_cnt;
   assign err_pulse   = r_err_pulse;

endmodule
`default_nettype wire

// File: rtl/link_pattern_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : link_pattern_gen_chk
// Description : Multi-lane link test-pattern generator and checker.
//               Optional: LINK_PATTERN_ERR_INJECT_EN adds the inject port.
// Revision    : 1.0 - initial release
// ============================================================================
module link_pattern_gen_chk
   import link_pattern_pkg::*;
#(
   parameter int          NUM_CH     = 8,
   parameter int          DATA_W     = 16,
   parameter int          CNT_W      = 16,
   parameter int          LOCK_N     = 8,
   parameter int          LOSS_N     = 4,
   parameter logic [31:0] FIXED_WORD = 32'h0000_BC50
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic                     enable,
   input  logic                     clr_cnt,
   input  logic [NUM_CH-1:0]        tx_ready,
`ifdef LINK_PATTERN_ERR_INJECT_EN
   input  logic [NUM_CH-1:0]        inject,
`endif
   output logic [NUM_CH*DATA_W-1:0] tx_data,
   output logic [NUM_CH-1:0]        tx_valid,
   input  logic [NUM_CH*DATA_W-1:0] rx_data,
   input  logic [NUM_CH-1:0]        rx_valid,
   output logic [NUM_CH-1:0]        lane_locked,
   output logic [NUM_CH*CNT_W-1:0]  err_cnt,
   output logic [NUM_CH-1:0]        err_pulse
);

   mode_e r_mode;
   mode_e w_new_mode;
   logic  w_reseed;

   assign w_new_mode = mode_e'(mode);
   assign w_reseed   = (w_new_mode != r_mode);

   // Reset mode matches the reset generator word (COUNTER seed is zero)
   always_ff @(posedge clk) begin
      if (rst) r_mode <= MODE_COUNTER;
      else     r_mode <= w_new_mode;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      link_pattern_lane #(
         .DATA_W     (DATA_W),
         .CNT_W      (CNT_W),
         .LOCK_N     (LOCK_N),
         .LOSS_N     (LOSS_N),
         .FIXED_WORD (FIXED_WORD)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .cur_mode    (r_mode),
         .new_mode    (w_new_mode),
         .reseed      (w_reseed),
         .enable      (enable),
         .clr_cnt     (clr_cnt),
         .tx_ready    (tx_ready[g]),
`ifdef LINK_PATTERN_ERR_INJECT_EN
         .inject      (inject[g]),
`endif
         .tx_data     (tx_data[g*DATA_W +: DATA_W]),
         .tx_valid    (tx_valid[g]),
         .rx_data     (rx_data[g*DATA_W +: DATA_W]),
         .rx_valid    (rx_valid[g]),
         .lane_locked (lane_locked[g]),
         .err_cnt     (err_cnt[g*CNT_W +: CNT_W]),
         .err_pulse   (err_pulse[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_link_pattern_gen_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_pattern_gen_chk
// Description : Self-checking bench for link_pattern_gen_chk (8-lane loopback
//               plus a narrow-counter instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_pattern_gen_chk;

   localparam int NUM_CH = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;
   localparam int LOCK_N = 8;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [1:0]               mode;
   logic                     enable;
   logic                     clr_cnt;
   logic [NUM_CH-1:0]        tx_ready;
   logic [NUM_CH*DATA_W-1:0] tx_data;
   logic [NUM_CH-1:0]        tx_valid;
   logic [NUM_CH*DATA_W-1:0] rx_data;
   logic [NUM_CH-1:0]        rx_valid;
   logic [NUM_CH-1:0]        lane_locked;
   logic [NUM_CH*CNT_W-1:0]  err_cnt;
   logic [NUM_CH-1:0]        err_pulse;

   logic [NUM_CH*DATA_W-1:0] xor_mask;
   logic                     ovr0;

   logic       s_en, s_clr, s_const;
   logic [7:0] s_tx_data, s_rx_data;
   logic       s_tx_valid, s_locked, s_err_pulse;
   logic [3:0] s_err_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Loopback with optional corruption
   always_comb begin
      rx_data = tx_data ^ xor_mask;
      if (ovr0) rx_data[DATA_W-1:0] = '0;
      rx_valid = tx_valid & tx_ready;
   end

   assign s_rx_data = s_const ? 8'h5A : s_tx_data;

   link_pattern_gen_chk #(
      .NUM_CH (NUM_CH), .DATA_W (DATA_W), .CNT_W (CNT_W), .LOCK_N (LOCK_N), .LOSS_N (4)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .mode        (mode),
      .enable      (enable),
      .clr_cnt     (clr_cnt),
      .tx_ready    (tx_ready),
`ifdef LINK_PATTERN_ERR_INJECT_EN
      .inject      ('0),
`endif
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .lane_locked (lane_locked),
      .err_cnt     (err_cnt),
      .err_pulse   (err_pulse)
   );

   link_pattern_gen_chk #(
      .NUM_CH (1), .DATA_W (8), .CNT_W (4), .LOCK_N (2), .LOSS_N (100)
   ) u_sat (
      .clk         (clk),
      .rst         (rst),
      .mode        (2'd0),
      .enable      (s_en),
      .clr_cnt     (s_clr),
      .tx_ready    (1'b1),
`ifdef LINK_PATTERN_ERR_INJECT_EN
      .inject      (1'b0),
`endif
      .tx_data     (s_tx_data),
      .tx_valid    (s_tx_valid),
      .rx_data     (s_rx_data),
      .rx_valid    (s_tx_valid),
      .lane_locked (s_locked),
      .err_cnt     (s_err_cnt),
      .err_pulse   (s_err_pulse)
   );

   // Successor words straight from the pattern definitions (16-bit lanes)
   function automatic logic [15:0] ref_next(input int m, input logic [15:0] w);
      case (m)
         0:       return w + 16'd1;
         1:       return (w == 16'd0) ? 16'd1 : {w[14:0], w[15] ^ w[14] ^ w[12] ^ w[3]};
         2:       return 16'hBC50;
         default: return (w == 16'd0) ? 16'd1 : {w[14:0], w[15]};
      endcase
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0]  w;
      logic [15:0]  m;
      logic [15:0]  wl [NUM_CH];
      logic [127:0] vec;
      logic [NUM_CH-1:0] rdy;
      logic [NUM_CH-1:0] pulses;
      int data_bad;
      int exp_cnt3;

      rst = 1'b1; enable = 1'b0; mode = 2'd0; clr_cnt = 1'b0; tx_ready = '1;
      xor_mask = '0; ovr0 = 1'b0; s_en = 1'b0; s_clr = 1'b0; s_const = 1'b0;
      repeat (3) tick();
      check("rst_tx_valid", 128'(tx_valid), 128'(0));
      check("rst_tx_data", 128'(tx_data), 128'(0));
      check("rst_locked", 128'(lane_locked), 128'(0));
      check("rst_err_cnt", 128'(err_cnt), 128'(0));
      check("rst_err_pulse", 128'(err_pulse), 128'(0));

      // COUNTER loopback: lock after one seek word plus LOCK_N matches
      rst = 1'b0; enable = 1'b1;
      tick();
      check("cnt_first_valid", 128'(tx_valid), 128'(8'hFF));
      check("cnt_first_word", 128'(tx_data), 128'(0));
      w = 16'd0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         w = ref_next(0, w);
         check("cnt_data", 128'(tx_data), {NUM_CH{w}});
         check("cnt_lock", 128'(lane_locked), 128'((n >= 1 + LOCK_N) ? 8'hFF : 8'h00));
      end
      pulses = '0; data_bad = 0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         w = ref_next(0, w);
         pulses |= err_pulse;
         if (tx_data !== {NUM_CH{w}}) data_bad++;
      end
      check("cnt_1000_data", 128'(data_bad), 128'(0));
      check("cnt_1000_pulse", 128'(pulses), 128'(0));
      check("cnt_1000_err_cnt", 128'(err_cnt), 128'(0));
      check("cnt_1000_locked", 128'(lane_locked), 128'(8'hFF));

      // PRBS with lane 3 word 200 corrupted
      mode = 2'd1;
      tick();
      check("prbs_seed", 128'(tx_data), {NUM_CH{16'd1}});
      check("prbs_unlock", 128'(lane_locked), 128'(0));
      w = 16'd1; exp_cnt3 = 0;
      for (int n = 0; n <= 220; n++) begin
         xor_mask = '0;
         if (n == 200) begin
            do m = 16'($urandom_range(1, 16'hFFFF));
            while (ref_next(1, w ^ m) == ref_next(1, w));
            xor_mask[3*DATA_W +: DATA_W] = m;
         end
         tick();
         w = ref_next(1, w);
         if (n == 200 || n == 201) exp_cnt3++;
         check("prbs_data", 128'(tx_data), {NUM_CH{w}});
         check("prbs_pulse", 128'(err_pulse), 128'((n == 200 || n == 201) ? 8'h08 : 8'h00));
      end
      xor_mask = '0;
      check("prbs_err_cnt", 128'(err_cnt), 128'(exp_cnt3) << (3 * CNT_W));
      check("prbs_err_cnt3_is_2", 128'(err_cnt[3*CNT_W +: CNT_W]), 128'(2));
      check("prbs_locked", 128'(lane_locked), 128'(8'hFF));

      // FIXED: lane 0 forced to zero for four words
      mode = 2'd2;
      tick();
      check("fixed_word", 128'(tx_data), {NUM_CH{16'hBC50}});
      repeat (10) tick();
      check("fixed_locked", 128'(lane_locked), 128'(8'hFF));
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("fixed_clr", 128'(err_cnt), 128'(0));
      ovr0 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("fixed_bad_cnt", 128'(err_cnt[CNT_W-1:0]), 128'(k));
         check("fixed_bad_lock", 128'(lane_locked[0]), 128'(k < 4));
      end
      ovr0 = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         check("fixed_relock", 128'(lane_locked[0]), 128'(j >= 8));
      end
      check("fixed_cnt_hold", 128'(err_cnt), 128'(4));
      check("fixed_others", 128'(lane_locked[NUM_CH-1:1]), 128'(7'h7F));

      // COUNTER with random per-lane tx_ready
      mode = 2'd0;
      tick();
      check("rdy_seed", 128'(tx_data), 128'(0));
      for (int i = 0; i < NUM_CH; i++) wl[i] = 16'd0;
      for (int n = 0; n < 60; n++) begin
         tx_ready = NUM_CH'($urandom);
         rdy = tx_ready;
         tick();
         for (int i = 0; i < NUM_CH; i++) begin
            if (rdy[i]) wl[i] = ref_next(0, wl[i]);
            vec[i*DATA_W +: DATA_W] = wl[i];
         end
         check("rdy_data", tx_data, vec);
      end
      tx_ready = '1;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      repeat (12) tick();
      check("rdy_err_cnt", 128'(err_cnt), 128'(0));
      check("rdy_locked", 128'(lane_locked), 128'(8'hFF));

      // Reset mid-lock
      rst = 1'b1;
      tick();
      check("mid_rst_locked", 128'(lane_locked), 128'(0));
      check("mid_rst_valid", 128'(tx_valid), 128'(0));
      check("mid_rst_data", 128'(tx_data), 128'(0));
      rst = 1'b0;
      repeat (3) tick();

      // COUNTER -> WALK1
      mode = 2'd3;
      tick();
      check("walk_seed", 128'(tx_data), {NUM_CH{16'd1}});
      check("walk_unlock", 128'(lane_locked), 128'(0));
      w = 16'd1;
      for (int n = 1; n <= 17; n++) begin
         tick();
         w = ref_next(3, w);
         check("walk_data", 128'(tx_data), {NUM_CH{w}});
         check("walk_lock", 128'(lane_locked), 128'((n >= 1 + LOCK_N) ? 8'hFF : 8'h00));
      end
      check("walk_wrap", 128'(tx_data[15:0]), 128'(16'h0002));

      // Saturation on a 4-bit counter with lock held by a large LOSS_N
      s_en = 1'b1;
      repeat (6) tick();
      check("sat_locked", 128'(s_locked), 128'(1));
      s_const = 1'b1;
      repeat (20) tick();
      check("sat_cnt", 128'(s_err_cnt), 128'(15));
      check("sat_still_locked", 128'(s_locked), 128'(1));
      check("sat_pulse", 128'(s_err_pulse), 128'(1));
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      check("sat_clr_with_err", 128'(s_err_cnt), 128'(1));
      tick();
      check("sat_after_clr", 128'(s_err_cnt), 128'(2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
